rot_scan_ctrl: RTL and testbench
================================

ROT_SCAN_CTRL -- requirements
Module: rot_scan_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of RF switch channels (2..8).
REQ-002 Parameter N_STEPS, default 360: rotator steps per full sweep (2..2^STEP_W).
REQ-003 Parameter STEP_W, default 10: width of rot_count.
REQ-004 Parameter SETTLE_CYC, default 50: fpga_clk cycles of RF settle after each channel change (>=1).
REQ-005 fpga_clk  in  1  sole clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stp_tick  in  1  one-cycle pulse per rotator step period, synchronous to fpga_clk.
REQ-008 sys_init_ctrl  in  1  one-cycle pulse: abort and zero position.
REQ-009 trg_ctrl  in  1  one-cycle pulse: start sweep.
REQ-010 adc_ack  in  1  ADC conversion complete.
REQ-011 cont  in  1  continuous-sweep request (present only with SCAN_CONT_EN).
REQ-012 rot_en  out  1  rotator step enable.
REQ-013 adc_req  out  1  ADC conversion request.
REQ-014 rf_sw  out  N_CH  one-hot RF channel select.
REQ-015 rot_count  out  STEP_W  current angular step index.
REQ-016 wrk_stat  out  1  high whenever state is not IDLE.
REQ-017 done  out  1  one-cycle pulse at sweep end.

Function
REQ-018 States SHALL be IDLE, STEP, SETTLE, MEAS, DONE.
REQ-019 IDLE: rot_en=0, adc_req=0, rf_sw=channel 0; trg_ctrl -> STEP next cycle, sweep step counter cleared.
REQ-020 STEP: rot_en=1; on stp_tick, rot_count increments, channel index=0, -> SETTLE; a stp_tick in the same cycle as trg_ctrl in IDLE SHALL NOT be counted.
REQ-021 rot_count SHALL wrap from N_STEPS-1 to 0, never exceeding N_STEPS-1.
REQ-022 SETTLE: rot_en=0; wait exactly SETTLE_CYC cycles, then -> MEAS with adc_req=1 in the first MEAS cycle.
REQ-023 MEAS: adc_req held high until the cycle adc_ack is sampled high; adc_req low the following cycle.
REQ-024 After ack: if channel < N_CH-1, channel increments, rf_sw updates same cycle, -> SETTLE; else if N_STEPS steps completed -> DONE, else -> STEP.
REQ-025 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-026 adc_ack outside MEAS and trg_ctrl outside IDLE SHALL be ignored.
REQ-027 sys_init_ctrl SHALL have priority over all events: -> IDLE, rot_count=0, channel=0, adc_req=0, no done pulse; simultaneous trg_ctrl ignored.
REQ-028 rf_sw SHALL always be exactly one-hot.

Reset
REQ-029 rst SHALL force IDLE, rot_count=0, channel=0, rf_sw=1, rot_en=0, adc_req=0, wrk_stat=0, done=0, settle and step counters 0.
REQ-030 rst mid-sweep SHALL abort without a done pulse.

Configuration
REQ-031 Macro ROT_SCAN_CONT_EN: when defined, port cont exists and DONE with cont=1 SHALL pulse done and go to STEP (step counter cleared) instead of IDLE.
REQ-032 Without ROT_SCAN_CONT_EN, no cont port; every sweep ends in IDLE.

Structure
REQ-033 Shared package rot_scan_pkg SHALL hold the state enumeration and default parameter constants.
REQ-034 One sub-module, settle_timer (load, count down, expire pulse), SHALL implement the SETTLE wait.

Verification (N_CH=2, N_STEPS=4, SETTLE_CYC=3, adc_ack 2 cycles after adc_req)
REQ-035 rst released, no stimulus -> rot_count=0, rf_sw=01, wrk_stat=0, done never asserted.
REQ-036 trg_ctrl then 4 stp_ticks -> rot_count 1,2,3,0; 8 adc_req/adc_ack pairs; rf_sw 01,10 per step; one done pulse; return to IDLE.
REQ-037 stp_tick coincident with trg_ctrl -> not counted; first increment on next tick.
REQ-038 sys_init_ctrl during MEAS at step 2 -> IDLE next cycle, rot_count=0, adc_req=0, no done.
REQ-039 adc_ack pulse while in SETTLE -> ignored; settle lasts exactly 3 cycles.
REQ-040 With ROT_SCAN_CONT_EN, cont=1 -> done pulses every sweep, wrk_stat stays 1, rot_count continues wrapping.

Source files
------------

// File: rtl/rot_scan_pkg.sv
// Shared definitions for the rotator scan controller: FSM state encoding and
// default parameter values used by rot_scan_ctrl and settle_timer.
package rot_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_t;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_N_STEPS    = 360;
    localparam int DEF_STEP_W     = 10;
    localparam int DEF_SETTLE_CYC = 50;

endpackage

// File: rtl/rot_scan_settle_timer.sv
// settle_timer: loadable down-counter that holds o_expire high during the last
// cycle of a CYCLES-long wait started by i_load.
module settle_timer
    import rot_scan_pkg::*;
#(
    parameter int CYCLES = DEF_SETTLE_CYC
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_load,
    output logic o_expire
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // Loading CYCLES-1 makes the expire cycle the CYCLES-th cycle after the load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= CNT_W'(CYCLES - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_expire = r_busy && (r_cnt == '0);

endmodule

// File: rtl/rot_scan_ctrl.sv
// rot_scan_ctrl: steps an antenna rotator through a sweep and, at each angle,
// cycles the RF switch over all channels with settle + ADC handshake.
// Optional continuous sweeping is enabled by defining ROT_SCAN_CONT_EN.
module rot_scan_ctrl
    import rot_scan_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int N_STEPS    = DEF_N_STEPS,
    parameter int STEP_W     = DEF_STEP_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              fpga_clk,
    input  logic              rst,
    input  logic              stp_tick,
    input  logic              sys_init_ctrl,
    input  logic              trg_ctrl,
    input  logic              adc_ack,
`ifdef ROT_SCAN_CONT_EN
    input  logic              cont,
`endif
    output logic              rot_en,
    output logic              adc_req,
    output logic [N_CH-1:0]   rf_sw,
    output logic [STEP_W-1:0] rot_count,
    output logic              wrk_stat,
    output logic              done
);

    localparam int                CH_W         = $clog2(N_CH);
    localparam logic [CH_W-1:0]   L_CH_LAST    = CH_W'(N_CH - 1);
    localparam logic [STEP_W-1:0] L_STEP_LAST  = STEP_W'(N_STEPS - 1);
    localparam logic [STEP_W:0]   L_STEPS_FULL = (STEP_W + 1)'(N_STEPS);

    scan_state_t       r_state;
    logic [STEP_W-1:0] r_rot_count;
    logic [STEP_W:0]   r_steps;
    logic [CH_W-1:0]   r_ch;
    logic [N_CH-1:0]   r_rf_sw;
    logic              r_rot_en;
    logic              r_adc_req;
    logic              r_wrk_stat;
    logic              r_done;

    logic              w_cont;
    logic              w_expire;
    logic              w_step_take;
    logic              w_ack_take;
    logic              w_ch_last;
    logic              w_timer_load;
    logic [CH_W-1:0]   w_ch_inc;
    logic [N_CH-1:0]   w_sel_inc;
    logic [STEP_W-1:0] w_rot_next;

`ifdef ROT_SCAN_CONT_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    assign w_step_take = (r_state == ST_STEP) && stp_tick;
    assign w_ack_take  = (r_state == ST_MEAS) && adc_ack;
    assign w_ch_last   = (r_ch == L_CH_LAST);
    assign w_ch_inc    = r_ch + CH_W'(1);
    assign w_rot_next  = (r_rot_count == L_STEP_LAST) ? '0 : r_rot_count + STEP_W'(1);

    // The timer must load on the same edge that enters SETTLE, so the load is
    // decoded from the transition conditions rather than from the new state.
    assign w_timer_load = !sys_init_ctrl && (w_step_take || (w_ack_take && !w_ch_last));

    // One-hot image of the next channel, registered into rf_sw on the channel advance.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_sel
            assign w_sel_inc[gi] = (w_ch_inc == CH_W'(gi));
        end
    endgenerate

    settle_timer #(
        .CYCLES (SETTLE_CYC)
    ) u_settle_timer (
        .i_clk    (fpga_clk),
        .i_rst    (rst),
        .i_clear  (sys_init_ctrl),
        .i_load   (w_timer_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rot_count <= '0;
            r_steps     <= '0;
            r_ch        <= '0;
            r_rf_sw     <= N_CH'(1);
            r_rot_en    <= 1'b0;
            r_adc_req   <= 1'b0;
            r_wrk_stat  <= 1'b0;
            r_done      <= 1'b0;
        end else if (sys_init_ctrl) begin
            r_state     <= ST_IDLE;
            r_rot_count <= '0;
            r_steps     <= '0;
            r_ch        <= '0;
            r_rf_sw     <= N_CH'(1);
            r_rot_en    <= 1'b0;
            r_adc_req   <= 1'b0;
            r_wrk_stat  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trg_ctrl) begin
                        r_state    <= ST_STEP;
                        r_steps    <= '0;
                        r_rot_en   <= 1'b1;
                        r_wrk_stat <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (stp_tick) begin
                        r_state     <= ST_SETTLE;
                        r_rot_count <= w_rot_next;
                        r_steps     <= r_steps + (STEP_W + 1)'(1);
                        r_ch        <= '0;
                        r_rf_sw     <= N_CH'(1);
                        r_rot_en    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_expire) begin
                        r_state   <= ST_MEAS;
                        r_adc_req <= 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (adc_ack) begin
                        r_adc_req <= 1'b0;
                        if (!w_ch_last) begin
                            r_state <= ST_SETTLE;
                            r_ch    <= w_ch_inc;
                            r_rf_sw <= w_sel_inc;
                        end else begin
                            // Back to channel 0 so IDLE and STEP always present rf_sw = 1.
                            r_ch    <= '0;
                            r_rf_sw <= N_CH'(1);
                            if (r_steps == L_STEPS_FULL) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state  <= ST_STEP;
                                r_rot_en <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (w_cont) begin
                        r_state  <= ST_STEP;
                        r_steps  <= '0;
                        r_rot_en <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_wrk_stat <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rot_en   <= 1'b0;
                    r_adc_req  <= 1'b0;
                    r_wrk_stat <= 1'b0;
                end
            endcase
        end
    end

    assign rot_en    = r_rot_en;
    assign adc_req   = r_adc_req;
    assign rf_sw     = r_rf_sw;
    assign rot_count = r_rot_count;
    assign wrk_stat  = r_wrk_stat;
    assign done      = r_done;

endmodule

// File: tb/tb_rot_scan_ctrl.sv
// Self-checking bench for rot_scan_ctrl (N_CH=2, N_STEPS=4, SETTLE_CYC=3):
// directed scenarios plus randomized stimulus against a cycle model.
module tb_rot_scan_ctrl;

    localparam int N_CH       = 2;
    localparam int N_STEPS    = 4;
    localparam int STEP_W     = 10;
    localparam int SETTLE_CYC = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_STEP   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_MEAS   = 3;
    localparam int PH_DONE   = 4;

    logic              fpga_clk = 1'b0;
    logic              rst = 1'b0;
    logic              stp_tick = 1'b0;
    logic              sys_init_ctrl = 1'b0;
    logic              trg_ctrl = 1'b0;
    logic              adc_ack = 1'b0;
`ifdef ROT_SCAN_CONT_EN
    logic              cont = 1'b0;
`endif
    logic              rot_en;
    logic              adc_req;
    logic [N_CH-1:0]   rf_sw;
    logic [STEP_W-1:0] rot_count;
    logic              wrk_stat;
    logic              done;

    rot_scan_ctrl #(
        .N_CH       (N_CH),
        .N_STEPS    (N_STEPS),
        .STEP_W     (STEP_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .fpga_clk      (fpga_clk),
        .rst           (rst),
        .stp_tick      (stp_tick),
        .sys_init_ctrl (sys_init_ctrl),
        .trg_ctrl      (trg_ctrl),
        .adc_ack       (adc_ack),
`ifdef ROT_SCAN_CONT_EN
        .cont          (cont),
`endif
        .rot_en        (rot_en),
        .adc_req       (adc_req),
        .rf_sw         (rf_sw),
        .rot_count     (rot_count),
        .wrk_stat      (wrk_stat),
        .done          (done)
    );

    always #5 fpga_clk = ~fpga_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit ack_rand = 1'b0;
    bit ack_force = 1'b0;

    // Model of the scan: phase, angular position, channel, steps this sweep, settle time spent.
    int m_phase = PH_IDLE;
    int m_pos = 0;
    int m_ch = 0;
    int m_steps = 0;
    int m_settle = 0;

    int req_age = 0;
    int done_cnt = 0;
    int req_rises = 0;
    int prev_rot = 0;
    bit prev_req = 1'b0;
    int rot_q[$];
    int rf_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge fpga_clk or posedge rst) begin : model
        int ph, pos, ch, st, se;
        bit cont_in;
        if (rst) begin
            m_phase  <= PH_IDLE;
            m_pos    <= 0;
            m_ch     <= 0;
            m_steps  <= 0;
            m_settle <= 0;
        end else begin
`ifdef ROT_SCAN_CONT_EN
            cont_in = cont;
`else
            cont_in = 1'b0;
`endif
            ph = m_phase; pos = m_pos; ch = m_ch; st = m_steps; se = m_settle;
            if (sys_init_ctrl) begin
                ph = PH_IDLE; pos = 0; ch = 0; st = 0; se = 0;
            end else begin
                case (ph)
                    PH_IDLE: if (trg_ctrl) begin ph = PH_STEP; st = 0; end
                    PH_STEP: if (stp_tick) begin
                        pos = (pos + 1) % N_STEPS;
                        st = st + 1; ch = 0; se = 0; ph = PH_SETTLE;
                    end
                    PH_SETTLE: begin
                        se = se + 1;
                        if (se == SETTLE_CYC) ph = PH_MEAS;
                    end
                    PH_MEAS: if (adc_ack) begin
                        if (ch < N_CH - 1) begin ch = ch + 1; se = 0; ph = PH_SETTLE; end
                        else begin ch = 0; ph = (st == N_STEPS) ? PH_DONE : PH_STEP; end
                    end
                    default: begin
                        if (cont_in) begin ph = PH_STEP; st = 0; end
                        else ph = PH_IDLE;
                    end
                endcase
            end
            m_phase  <= ph;
            m_pos    <= pos;
            m_ch     <= ch;
            m_steps  <= st;
            m_settle <= se;
        end
    end

    always @(negedge fpga_clk) begin
        if (chk_en) begin
            chk("rot_en", rot_en, m_phase == PH_STEP);
            chk("adc_req", adc_req, m_phase == PH_MEAS);
            chk("wrk_stat", wrk_stat, m_phase != PH_IDLE);
            chk("done", done, m_phase == PH_DONE);
            chk("rot_count", rot_count, m_pos);
            chk("rot_range", rot_count < N_STEPS, 1);
            chk("rf_onehot", $onehot(rf_sw), 1);
            if (m_phase == PH_IDLE || m_phase == PH_SETTLE || m_phase == PH_MEAS)
                chk("rf_sw", rf_sw, 32'd1 << m_ch);
        end
        if (int'(rot_count) != prev_rot) rot_q.push_back(int'(rot_count));
        prev_rot = int'(rot_count);
        if (adc_req && !prev_req) begin
            rf_q.push_back(int'(rf_sw));
            req_rises++;
        end
        prev_req = adc_req;
        if (done) done_cnt++;
        req_age = adc_req ? req_age + 1 : 0;
    end

    task automatic drive(input logic t, input logic tr, input logic in);
        @(negedge fpga_clk);
        #1;
        stp_tick = t;
        trg_ctrl = tr;
        sys_init_ctrl = in;
        if (ack_rand) adc_ack = ($urandom_range(0, 2) == 0);
        else adc_ack = ack_force || (req_age == 3);
    endtask

    task automatic run_to_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 1; i <= max_cyc; i++) begin
            drive((i % 16) == 0, 1'b0, 1'b0);
            if (!wrk_stat) begin ok = 1'b1; break; end
        end
        chk("sweep_end", ok, 1);
    endtask

    task automatic run_to_meas(input int at_pos);
        bit found;
        found = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            drive((i % 16) == 0, 1'b0, 1'b0);
            if (adc_req && int'(rot_count) == at_pos) begin found = 1'b1; break; end
        end
        chk("meas_found", found, 1);
    endtask

    initial begin
        int d0, settle_n;
        #2 rst = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("rst_rot", rot_count, 0);
        chk("rst_rf", rf_sw, 1);
        chk("rst_wrk", wrk_stat, 0);
        chk("rst_done", done, 0);
        chk("rst_roten", rot_en, 0);
        chk("rst_adc", adc_req, 0);
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (10) drive(1'b0, 1'b0, 1'b0);
        chk("idle_done", done_cnt, 0);
        chk("idle_wrk", wrk_stat, 0);
        chk("idle_rf", rf_sw, 1);

        // Full sweep: angles 1,2,3,0, two channels per angle, one done.
        rot_q.delete(); rf_q.delete(); req_rises = 0; d0 = done_cnt;
        drive(1'b0, 1'b1, 1'b0);
        run_to_idle(300);
        chk("sweep_rot_n", rot_q.size(), 4);
        for (int i = 0; i < rot_q.size() && i < 4; i++) chk("sweep_rot_seq", rot_q[i], (i + 1) % 4);
        chk("sweep_reqs", req_rises, 8);
        for (int i = 0; i < rf_q.size() && i < 8; i++) chk("sweep_rf_seq", rf_q[i], (i % 2 == 0) ? 1 : 2);
        chk("sweep_done", done_cnt - d0, 1);

        // Tick coincident with trigger is not counted.
        drive(1'b1, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk("coinc_rot", rot_count, 0);
        chk("coinc_step", rot_en, 1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("first_inc", rot_count, 1);
        run_to_idle(300);
        chk("coinc_end_rot", rot_count, 0);

        // sys_init during MEAS at step 2.
        d0 = done_cnt;
        run_to_meas(2);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("init_wrk", wrk_stat, 0);
        chk("init_rot", rot_count, 0);
        chk("init_adc", adc_req, 0);
        chk("init_rf", rf_sw, 1);
        repeat (8) drive(1'b0, 1'b0, 1'b0);
        chk("init_nodone", done_cnt - d0, 0);

        // Asynchronous rst mid-sweep.
        d0 = done_cnt;
        run_to_meas(1);
        rst = 1'b1;
        #2;
        chk("arst_wrk", wrk_stat, 0);
        chk("arst_rot", rot_count, 0);
        chk("arst_adc", adc_req, 0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk("arst_nodone", done_cnt - d0, 0);

        // Spurious ack in SETTLE; settle must still be exactly 3 cycles.
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        ack_force = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        ack_force = 1'b0;
        settle_n = adc_req ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            if (adc_req) break;
            settle_n++;
        end
        chk("settle_len", settle_n, 3);
        run_to_idle(300);

`ifdef ROT_SCAN_CONT_EN
        begin
            int drops;
            drops = 0;
            d0 = done_cnt;
            cont = 1'b1;
            drive(1'b0, 1'b1, 1'b0);
            for (int i = 1; i <= 600; i++) begin
                drive((i % 16) == 0, 1'b0, 1'b0);
                if (!wrk_stat) drops++;
            end
            chk("cont_wrk_drops", drops, 0);
            chk("cont_done_many", (done_cnt - d0) >= 5, 1);
            cont = 1'b0;
            run_to_idle(300);
        end
`endif

        // Randomized stimulus, checked cycle by cycle against the model.
        ack_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
`ifdef ROT_SCAN_CONT_EN
            cont = ($urandom_range(0, 1) == 0);
`endif
            rst = ($urandom_range(0, 499) == 0);
        end
        ack_rand = 1'b0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("final_idle", wrk_stat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
